// File: rtl/dyn_phs_pkg.sv
// Shared codes for the phase-shift sequencer and the
// dyn_phase_shift_FSM it drives.
package dyn_phs_pkg;

  localparam int PHASE_W_DEF = 10;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_REQ   = 2'd1,
    SEQ_WDONE = 2'd2,
    SEQ_RSVD  = 2'd3
  } seq_state_e;

  typedef enum logic [2:0] {
    FSM_IDLE      = 3'b000,
    FSM_INC_DEC   = 3'b001,
    FSM_STANDBY   = 3'b010,
    FSM_W4LOCK    = 3'b011,
    FSM_W4_PSDONE = 3'b100
  } fsm_state_e;

endpackage

// File: rtl/dyn_phase_shift_seq.sv
// Walks the MMCM fine phase toward a clamped signed
// target, one PH_CHANGE/BUSY handshake per step.
module dyn_phase_shift_seq
  import dyn_phs_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int PH_MAX  = 511,
  parameter int PH_MIN  = -511,
  parameter int TMO     = 15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               LOAD,
  input  logic [PHASE_W-1:0] TARGET,
  input  logic               BUSY,
  input  logic [2:0]         DYN_PHS_STATE,
  output logic               PH_CHANGE,
  output logic               INCDEC,
  output logic [PHASE_W-1:0] CUR_PHASE,
  output logic               AT_TARGET,
  output logic               ERR,
  output logic [1:0]         SEQ_STATE
);

  typedef logic signed [PHASE_W-1:0] ph_t;

  localparam ph_t        PMAX     = ph_t'(PH_MAX);
  localparam ph_t        PMIN     = ph_t'(PH_MIN);
  localparam logic [3:0] TMO_LAST = 4'(TMO - 1);

  seq_state_e state;
  ph_t        tgt_in;
  ph_t        tgt_clamped;
  ph_t        tgt_q;
  ph_t        cur_q;
  logic [3:0] tmo_cnt;
  logic       go_q;
  logic       standby;
  logic       can_go;
  logic       up;

  assign tgt_in  = TARGET;
  assign standby = (DYN_PHS_STATE == FSM_STANDBY);
  assign can_go  = standby && !ERR && (tgt_q != cur_q);
  assign up      = (tgt_q > cur_q);

  always_comb begin
    tgt_clamped = tgt_in;
    if (tgt_in > PMAX)
      tgt_clamped = PMAX;
    else if (tgt_in < PMIN)
      tgt_clamped = PMIN;
  end

  // go_q gives the IDLE compare its own cycle, so a
  // freshly updated CUR_PHASE or TGT_Q is seen first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= SEQ_IDLE;
      tgt_q     <= '0;
      cur_q     <= '0;
      tmo_cnt   <= '0;
      go_q      <= 1'b0;
      PH_CHANGE <= 1'b0;
      INCDEC    <= 1'b0;
      ERR       <= 1'b0;
      AT_TARGET <= 1'b0;
    end else begin
      go_q      <= 1'b0;
      AT_TARGET <= (state == SEQ_IDLE)
                   && (cur_q == tgt_q);
      unique case (state)
        SEQ_IDLE: begin
          go_q <= can_go;
          if (go_q && can_go) begin
            state     <= SEQ_REQ;
            INCDEC    <= up;
            PH_CHANGE <= 1'b1;
            tmo_cnt   <= '0;
            go_q      <= 1'b0;
          end
        end
        SEQ_REQ: begin
          if (BUSY) begin
            PH_CHANGE <= 1'b0;
            state     <= SEQ_WDONE;
          end else if (tmo_cnt == TMO_LAST) begin
            PH_CHANGE <= 1'b0;
            ERR       <= 1'b1;
            state     <= SEQ_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        SEQ_WDONE: begin
          if (!BUSY) begin
            cur_q <= INCDEC ? cur_q + ph_t'(1)
                            : cur_q - ph_t'(1);
            state <= SEQ_IDLE;
          end
        end
        default: begin
          state     <= SEQ_IDLE;
          PH_CHANGE <= 1'b0;
          INCDEC    <= 1'b0;
        end
      endcase
      if (LOAD) begin
        tgt_q <= tgt_clamped;
        ERR   <= 1'b0;
      end
    end
  end

  assign CUR_PHASE = cur_q;
  assign SEQ_STATE = state;

endmodule

// File: tb/tb_dyn_phase_shift_seq.sv
// Bench for dyn_phase_shift_seq with a behavioural
// phase-shift FSM and a step-level reference model.
module tb_dyn_phase_shift_seq;

  localparam int PW = 12;

  logic          CLK = 1'b0;
  logic          RST;
  logic          LOAD;
  logic [PW-1:0] TARGET;
  logic          BUSY;
  logic [2:0]    DYN_PHS_STATE;
  logic          PH_CHANGE;
  logic          INCDEC;
  logic [PW-1:0] CUR_PHASE;
  logic          AT_TARGET;
  logic          ERR;
  logic [1:0]    SEQ_STATE;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  dyn_phase_shift_seq #(
    .PHASE_W(PW), .PH_MAX(511),
    .PH_MIN(-511), .TMO(15)
  ) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD),
    .TARGET(TARGET), .BUSY(BUSY),
    .DYN_PHS_STATE(DYN_PHS_STATE),
    .PH_CHANGE(PH_CHANGE), .INCDEC(INCDEC),
    .CUR_PHASE(CUR_PHASE), .AT_TARGET(AT_TARGET),
    .ERR(ERR), .SEQ_STATE(SEQ_STATE)
  );

  // Behavioural FSM: accepts a request in Standby,
  // then holds BUSY for blen cycles.
  logic hold_lock = 1'b0;
  logic stuck     = 1'b0;
  int   blen      = 2;
  int   busy_left = 0;

  always @(posedge CLK) begin
    if (RST)
      busy_left <= 0;
    else if (busy_left > 0)
      busy_left <= busy_left - 1;
    else if (PH_CHANGE && !hold_lock && !stuck)
      busy_left <= blen;
  end

  assign BUSY = (busy_left > 0);
  assign DYN_PHS_STATE = hold_lock ? 3'b011 :
                         BUSY ? 3'b001 : 3'b010;

  // Request/phase history for step-level checks.
  int   widths[$];
  bit   dirs[$];
  int   cps[$];
  int   cur_w   = 0;
  logic prev_ph = 1'b0;
  int   prev_cp = 0;

  always @(negedge CLK) begin
    if (PH_CHANGE) begin
      cur_w = cur_w + 1;
      if (!prev_ph) dirs.push_back(INCDEC);
    end else if (cur_w != 0) begin
      widths.push_back(cur_w);
      cur_w = 0;
    end
    prev_ph = PH_CHANGE;
    if (int'($signed(CUR_PHASE)) != prev_cp) begin
      prev_cp = int'($signed(CUR_PHASE));
      cps.push_back(prev_cp);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog sim time exhausted");
    $fatal(1);
  end

  function automatic int clampf(input int t);
    if (t > 511) return 511;
    if (t < -511) return -511;
    return t;
  endfunction

  function automatic int cur();
    return int'($signed(CUR_PHASE));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    widths.delete();
    dirs.delete();
    cps.delete();
    cur_w = 0;
  endtask

  task automatic settle(output bit ok,
                        input int budget);
    ok = 1'b0;
    tick(2);
    for (int i = 0; i < budget; i++) begin
      if (SEQ_STATE == 2'd0 && AT_TARGET
          && !PH_CHANGE) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; LOAD = 1'b0; TARGET = '0;
    tick(2);
    n_cmp++; if (PH_CHANGE !== 1'b0) begin n_bad++; $display("FAIL rst PH_CHANGE got %b want 0", PH_CHANGE); end
    n_cmp++; if (INCDEC !== 1'b0) begin n_bad++; $display("FAIL rst INCDEC got %b want 0", INCDEC); end
    n_cmp++; if (CUR_PHASE !== '0) begin n_bad++; $display("FAIL rst CUR_PHASE got %0d want 0", cur()); end
    n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL rst ERR got %b want 0", ERR); end
    n_cmp++; if (SEQ_STATE !== 2'd0) begin n_bad++; $display("FAIL rst SEQ_STATE got %0d want 0", SEQ_STATE); end
    RST = 1'b0;
    tick(1);
    n_cmp++; if (AT_TARGET !== 1'b1) begin n_bad++; $display("FAIL rst AT_TARGET got %b want 1", AT_TARGET); end
  endtask

  task automatic test_walk(input string nm,
                           input int tgt);
    int start, fin, nsteps, bw, bd, bc, e;
    bit up, ok;
    start  = cur();
    fin    = clampf(tgt);
    up     = fin > start;
    nsteps = up ? fin - start : start - fin;
    clear_mon();
    LOAD = 1'b1; TARGET = tgt[PW-1:0];
    tick(1);
    LOAD = 1'b0;
    n_cmp++; if (PH_CHANGE !== 1'b0) begin n_bad++; $display("FAIL %s lat_k PH_CHANGE got %b want 0", nm, PH_CHANGE); end
    tick(1);
    n_cmp++; if (PH_CHANGE !== 1'b0) begin n_bad++; $display("FAIL %s lat_k1 PH_CHANGE got %b want 0", nm, PH_CHANGE); end
    tick(1);
    n_cmp++; if (PH_CHANGE !== 1'b1) begin n_bad++; $display("FAIL %s lat_k2 PH_CHANGE got %b want 1", nm, PH_CHANGE); end
    settle(ok, nsteps * 12 + 50);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s settle timeout got cur %0d want %0d", nm, cur(), fin); end
    bw = 0; bd = 0; bc = 0;
    foreach (widths[i]) if (widths[i] != 2) bw++;
    foreach (dirs[i]) if (dirs[i] != up) bd++;
    for (int i = 0; i < nsteps; i++) begin
      e = up ? start + i + 1 : start - i - 1;
      if (i >= cps.size() || cps[i] != e) bc++;
    end
    n_cmp++; if (widths.size() != nsteps) begin n_bad++; $display("FAIL %s steps got %0d want %0d", nm, widths.size(), nsteps); end
    n_cmp++; if (bw != 0) begin n_bad++; $display("FAIL %s pulse_width got %0d bad want 0 bad", nm, bw); end
    n_cmp++; if (bd != 0 || dirs.size() != nsteps) begin n_bad++; $display("FAIL %s incdec got %0d bad/%0d want 0/%0d", nm, bd, dirs.size(), nsteps); end
    n_cmp++; if (bc != 0 || cps.size() != nsteps) begin n_bad++; $display("FAIL %s phase_seq got %0d bad/%0d want 0/%0d", nm, bc, cps.size(), nsteps); end
    n_cmp++; if (cur() != fin) begin n_bad++; $display("FAIL %s final got %0d want %0d", nm, cur(), fin); end
    n_cmp++; if (AT_TARGET !== 1'b1 || ERR !== 1'b0) begin n_bad++; $display("FAIL %s flags got at=%b err=%b want 1 0", nm, AT_TARGET, ERR); end
  endtask

  task automatic test_random_walks();
    int d;
    for (int n = 0; n < 4; n++) begin
      blen = int'($urandom_range(1, 5));
      d = int'($urandom_range(1, 12));
      if ($urandom_range(0, 1) == 0) d = -d;
      test_walk("rand", cur() + d);
    end
  endtask

  task automatic test_retarget();
    int start, bc, e, n;
    bit ok;
    int exp_c[$];
    start = cur();
    blen = 4;
    clear_mon();
    LOAD = 1'b1; TARGET = 12'(start + 6);
    tick(1);
    LOAD = 1'b0;
    n = 0;
    while (SEQ_STATE != 2'd2 && n < 40) begin tick(1); n++; end
    n_cmp++; if (SEQ_STATE != 2'd2) begin n_bad++; $display("FAIL retgt reach_wdone got %0d want 2", SEQ_STATE); end
    LOAD = 1'b1; TARGET = 12'(start - 3);
    tick(1);
    LOAD = 1'b0;
    settle(ok, 200);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL retgt settle timeout got cur %0d want %0d", cur(), start - 3); end
    exp_c = {start + 1, start, start - 1,
             start - 2, start - 3};
    bc = 0;
    for (int i = 0; i < 5; i++) begin
      e = exp_c[i];
      if (i >= cps.size() || cps[i] != e) bc++;
    end
    n_cmp++; if (bc != 0 || cps.size() != 5) begin n_bad++; $display("FAIL retgt phase_seq got %0d bad/%0d want 0/5", bc, cps.size()); end
    n_cmp++; if (dirs.size() != 5 || dirs[0] != 1'b1 || dirs[1] != 1'b0) begin n_bad++; $display("FAIL retgt dirs got n=%0d want 5 (1,0,...)", dirs.size()); end
  endtask

  task automatic test_lock_hold();
    int tgt, nph;
    bit ok;
    tgt = cur() + 5;
    blen = 2;
    hold_lock = 1'b1;
    LOAD = 1'b1; TARGET = tgt[PW-1:0];
    tick(1);
    LOAD = 1'b0;
    nph = 0;
    for (int i = 0; i < 30; i++) begin
      if (PH_CHANGE) nph++;
      tick(1);
    end
    n_cmp++; if (nph != 0) begin n_bad++; $display("FAIL lock ph_during_lock got %0d want 0", nph); end
    n_cmp++; if (ERR !== 1'b0 || SEQ_STATE !== 2'd0) begin n_bad++; $display("FAIL lock idle got err=%b st=%0d want 0 0", ERR, SEQ_STATE); end
    hold_lock = 1'b0;
    tick(1);
    n_cmp++; if (PH_CHANGE !== 1'b0) begin n_bad++; $display("FAIL lock rel_r1 PH_CHANGE got %b want 0", PH_CHANGE); end
    tick(1);
    n_cmp++; if (PH_CHANGE !== 1'b1) begin n_bad++; $display("FAIL lock rel_r2 PH_CHANGE got %b want 1", PH_CHANGE); end
    settle(ok, 100);
    n_cmp++; if (!ok || cur() != tgt) begin n_bad++; $display("FAIL lock final got %0d want %0d", cur(), tgt); end
  endtask

  task automatic test_timeout();
    int start, tgt, n, w0;
    bit ok;
    start = cur();
    tgt = start + 1;
    stuck = 1'b1;
    clear_mon();
    LOAD = 1'b1; TARGET = tgt[PW-1:0];
    tick(1);
    LOAD = 1'b0;
    n = 0;
    while (!ERR && n < 60) begin tick(1); n++; end
    n_cmp++; if (ERR !== 1'b1) begin n_bad++; $display("FAIL tmo err_rise got %b want 1", ERR); end
    tick(40);
    w0 = widths.size() > 0 ? widths[0] : -1;
    n_cmp++; if (widths.size() != 1) begin n_bad++; $display("FAIL tmo requests got %0d want 1", widths.size()); end
    n_cmp++; if (w0 != 15) begin n_bad++; $display("FAIL tmo req_width got %0d want 15", w0); end
    n_cmp++; if (cur() != start || ERR !== 1'b1) begin n_bad++; $display("FAIL tmo hold got cur=%0d err=%b want %0d 1", cur(), ERR, start); end
    n_cmp++; if (SEQ_STATE !== 2'd0 || AT_TARGET !== 1'b0) begin n_bad++; $display("FAIL tmo state got st=%0d at=%b want 0 0", SEQ_STATE, AT_TARGET); end
    stuck = 1'b0;
    clear_mon();
    LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
    n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL tmo load_clears got %b want 0", ERR); end
    settle(ok, 100);
    n_cmp++; if (!ok || cur() != tgt || widths.size() != 1) begin n_bad++; $display("FAIL tmo rearm got cur=%0d n=%0d want %0d 1", cur(), widths.size(), tgt); end
  endtask

  task automatic test_rst_midstep();
    int n;
    blen = 3;
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(1);
    clear_mon();
    LOAD = 1'b1; TARGET = 12'd4;
    tick(1);
    LOAD = 1'b0;
    n = 0;
    while (!(cps.size() == 1 && SEQ_STATE == 2'd2)
           && n < 100) begin
      tick(1);
      n++;
    end
    n_cmp++; if (!(cps.size() == 1 && SEQ_STATE == 2'd2)) begin n_bad++; $display("FAIL rstmid reach got n=%0d st=%0d want 1 2", cps.size(), SEQ_STATE); end
    RST = 1'b1;
    tick(1);
    n_cmp++; if (cur() != 0 || PH_CHANGE !== 1'b0 || SEQ_STATE !== 2'd0) begin n_bad++; $display("FAIL rstmid clear got cur=%0d ph=%b st=%0d want 0 0 0", cur(), PH_CHANGE, SEQ_STATE); end
    RST = 1'b0;
    tick(1);
    test_walk("rstmid_walk", 4);
  endtask

  task automatic test_clamp();
    blen = 2;
    test_walk("clamp_hi", 700);
    test_walk("clamp_lo", -900);
  endtask

  initial begin
    RST = 1'b1; LOAD = 1'b0; TARGET = '0;
    test_reset();
    blen = int'($urandom_range(1, 5));
    test_walk("up3", 3);
    blen = int'($urandom_range(1, 5));
    test_walk("down_m2", -2);
    test_random_walks();
    test_retarget();
    test_lock_hold();
    test_timeout();
    test_rst_midstep();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
